if_fetch_stage: RTL
===================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have ports: clk_i in 1 clock; rst_i in 1 reset; one clock, reset synchronous and active-low.
REQ-002 SHALL have stall_i in 1: hazard-unit request to hold the IF/ID outputs.
REQ-003 SHALL have redirect_i in 1 and redirect_pc_i in 32: branch/jump resolved in ID; squash fetch and load new PC.
REQ-004 SHALL have imem_req_o out 1, imem_addr_o out 32, imem_ack_i in 1, imem_data_i in 32: instruction-memory request/ack port.
REQ-005 SHALL have pc_o out 32 (fetched address + 4), instruction_o out 32, valid_o out 1: IF/ID register feeding the decode stage.
REQ-006 SHALL have fetch_busy_o out 1: high while a memory request is outstanding.

Function
REQ-007 SHALL implement FSM states IDLE, REQ, HOLD, DRAIN; the internal pc_r register holds the next fetch address.
REQ-008 IDLE: imem_req_o=0; SHALL go to REQ on the next cycle.
REQ-009 REQ: imem_req_o=1, imem_addr_o=addr_r latched on entry; addr_r SHALL stay stable until ack.
REQ-010 REQ, ack, stall_i=0: IF/ID <= {addr_r+4, imem_data_i, valid=1}; pc_r <= addr_r+4; SHALL remain in REQ with new request next cycle (1 instr/cycle with 0-wait memory).
REQ-011 REQ, ack, stall_i=1: imem_data_i SHALL be captured in a 1-entry hold buffer; IF/ID unchanged; go HOLD.
REQ-012 HOLD: imem_req_o=0; when stall_i=0, buffer SHALL load into IF/ID, pc_r advances by 4, go REQ.
REQ-013 stall_i=1 and no ack: IF/ID and pc_r SHALL be unchanged.
REQ-014 redirect_i=1 (any state): IF/ID SHALL be zeroed (pc_o=0, instruction_o=0, valid_o=0); pc_r <= redirect_pc_i.
REQ-015 redirect_i has priority over stall_i; flush SHALL occur even while stalled.
REQ-016 redirect in REQ with ack same cycle: response SHALL be discarded; next state REQ at redirect_pc_i.
REQ-017 redirect in REQ without ack: SHALL go DRAIN; request held at old addr_r until ack; response dropped; then REQ at pc_r.
REQ-018 redirect in HOLD: buffer SHALL be discarded; go REQ.
REQ-019 redirect during DRAIN: pc_r SHALL be updated to the latest redirect_pc_i; drain continues.
REQ-020 PC arithmetic SHALL be 32-bit modulo; 0xFFFFFFFC+4 wraps to 0x00000000.
REQ-021 fetch_busy_o SHALL equal imem_req_o.

Reset
REQ-022 rst_i=0 at a clock edge: state=IDLE, pc_r=0, addr_r=0, pc_o=0, instruction_o=0, valid_o=0, imem_req_o=0, hold buffer invalid.
REQ-023 Reset mid-request SHALL abandon the transaction; a late ack in IDLE SHALL be ignored.

Configuration
REQ-024 With IF_PERF_CNT_EN defined: SHALL add outputs fetch_cnt_o 32 (+1 per instruction loaded into IF/ID with valid=1) and bubble_cnt_o 32 (+1 per cycle in REQ/HOLD/DRAIN without IF/ID load); both reset to 0, wrap at 2^32.
REQ-025 Without IF_PERF_CNT_EN: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-026 Reset, 0-wait memory, 4 cycles -> pc_o sequence 0x4,0x8,0xC,0x10, valid_o=1 each.
REQ-027 Ack with stall_i=1 for 3 cycles at addr 0x20 -> IF/ID unchanged 3 cycles, then instruction 0x20 loaded with pc_o=0x24.
REQ-028 redirect_i=1, redirect_pc_i=0x100 with ack same cycle -> IF/ID zeroed, next imem_addr_o=0x100, old data never on instruction_o.
REQ-029 Memory 3-cycle latency, redirect to 0x200 in first wait cycle -> imem_addr_o stays old until ack, response dropped, next request 0x200.
REQ-030 pc_r=0xFFFFFFFC fetch -> pc_o=0x00000000, next imem_addr_o=0x0.
REQ-031 IF_PERF_CNT_EN, 5 fetches plus 2 stall cycles -> fetch_cnt_o=5, bubble_cnt_o=2.

Source files
------------

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage of the in-order pipeline. Issues one request at a
// time to instruction memory, loads the returned word into the IF/ID register,
// and handles hazard stalls (1-entry hold buffer) and ID-stage redirects
// (squash plus optional drain of an in-flight request).
//
// Ports
//   clk_i          clock
//   rst_i          synchronous reset, active low
//   stall_i        hazard unit: hold IF/ID contents
//   redirect_i     branch/jump resolved in ID: squash and refetch
//   redirect_pc_i  redirect target address
//   imem_req_o     instruction-memory request (held until imem_ack_i)
//   imem_addr_o    request address, stable while imem_req_o is high
//   imem_ack_i     memory acknowledge, imem_data_i valid in the same cycle
//   imem_data_i    instruction word returned by memory
//   pc_o           IF/ID: fetched address + 4
//   instruction_o  IF/ID: fetched instruction
//   valid_o        IF/ID: entry valid
//   fetch_busy_o   high while a memory request is outstanding
//
// Build option
//   IF_PERF_CNT_EN  adds fetch_cnt_o (instructions loaded into IF/ID) and
//                   bubble_cnt_o (active cycles without an IF/ID load).
// -----------------------------------------------------------------------------
module if_fetch_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o,
    output logic        valid_o,
    output logic        fetch_busy_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o
`endif
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned ST_W = 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // Bit 0 of the encoding is exactly "request outstanding".
    typedef enum logic [ST_W-1:0] {
        S_IDLE  = 2'b00,
        S_REQ   = 2'b01,
        S_HOLD  = 2'b10,
        S_DRAIN = 2'b11
    } state_e;

    state_e          state_r;
    state_e          state_nxt;

    logic [XLEN-1:0] pc_r;         // next fetch address
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] addr_r;       // address of the request in flight
    logic [XLEN-1:0] addr_inc;
    logic [XLEN-1:0] hold_data_r;  // word acked while stalled
    logic            hold_vld_r;
    logic [XLEN-1:0] ifid_data;

    logic            ifid_load;
    logic            ifid_flush;
    logic            hold_set;
    logic            addr_load;

    assign addr_inc = addr_r + PC_STEP;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_r;
        unique case (state_r)
            S_IDLE: begin
                state_nxt = S_REQ;
            end
            S_REQ: begin
                if (redirect_i) begin
                    // An unacked request must still complete before refetching.
                    state_nxt = imem_ack_i ? S_REQ : S_DRAIN;
                end else if (imem_ack_i && stall_i) begin
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_i || !stall_i) begin
                    state_nxt = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_ack_i) begin
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Memory-port outputs decoded from state
    always_comb begin
        imem_req_o   = 1'b0;
        fetch_busy_o = 1'b0;
        imem_addr_o  = addr_r;
        if ((state_r == S_REQ) || (state_r == S_DRAIN)) begin
            imem_req_o   = 1'b1;
            fetch_busy_o = 1'b1;
        end
    end

    // Datapath control: IF/ID load/flush, hold capture, next PC
    always_comb begin
        ifid_load  = 1'b0;
        ifid_flush = redirect_i;
        ifid_data  = imem_data_i;
        hold_set   = 1'b0;
        pc_nxt     = redirect_i ? redirect_pc_i : pc_r;

        // Redirect wins over everything: responses and hold contents are dropped.
        if (!redirect_i) begin
            unique case (state_r)
                S_REQ: begin
                    if (imem_ack_i) begin
                        if (stall_i) begin
                            hold_set = 1'b1;
                        end else begin
                            ifid_load = 1'b1;
                            pc_nxt    = addr_inc;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall_i && hold_vld_r) begin
                        ifid_load = 1'b1;
                        ifid_data = hold_data_r;
                        pc_nxt    = addr_inc;
                    end
                end
                default: begin
                end
            endcase
        end

        // A fresh request address is taken whenever REQ starts a new access.
        addr_load = (state_nxt == S_REQ) && ((state_r != S_REQ) || imem_ack_i);
    end

    // PC, request address, hold buffer and IF/ID register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc_r          <= '0;
            addr_r        <= '0;
            hold_data_r   <= '0;
            hold_vld_r    <= 1'b0;
            pc_o          <= '0;
            instruction_o <= '0;
            valid_o       <= 1'b0;
        end else begin
            pc_r       <= pc_nxt;
            hold_vld_r <= (state_nxt == S_HOLD);
            if (addr_load) begin
                addr_r <= pc_nxt;
            end
            if (hold_set) begin
                hold_data_r <= imem_data_i;
            end
            if (ifid_flush) begin
                pc_o          <= '0;
                instruction_o <= '0;
                valid_o       <= 1'b0;
            end else if (ifid_load) begin
                pc_o          <= addr_inc;
                instruction_o <= ifid_data;
                valid_o       <= 1'b1;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    // Performance counters; both wrap modulo 2^32.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fetch_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (ifid_load) begin
                fetch_cnt_o <= fetch_cnt_o + XLEN'(1);
            end
            if ((state_r != S_IDLE) && !ifid_load) begin
                bubble_cnt_o <= bubble_cnt_o + XLEN'(1);
            end
        end
    end
`endif

endmodule
